// File: rtl/dmem_access_unit.sv
// Data-memory access stage: byte-lane/replicated store formatting and the req/gnt/rvalid handshake.
// Optional watchdog abort enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_unit #(
   parameter int MEM_LAT_MAX    = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqWdata,
   input  logic [1:0]  reqMemOp,
   input  logic [1:0]  reqMemSize,
   output logic        memReq,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [3:0]  memBe,
   output logic [31:0] memWdata,
   input  logic        memGnt,
   input  logic        memRvalid,
   input  logic [31:0] memRdata,
   output logic        respValid,
   output logic [31:0] respRawData,
   output logic [31:0] respAddr,
   output logic [1:0]  respMemOp,
   output logic [1:0]  respMemSize,
   output logic        respMisalign,
   output logic        respBusErr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t      state, state_next;
   logic        accept, is_mem, misaligned, expired, abort;
   logic        we_q, bus_err_q;
   logic [31:0] cap_addr;
   logic [1:0]  cap_op, cap_size;

   // The watchdog must outlast the slowest legal memory response.
   if (TIMEOUT_CYCLES <= MEM_LAT_MAX) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must exceed MEM_LAT_MAX");
   end

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   lane_be = 4'b0001 << lo;
         2'b01:   lane_be = 4'b0011 << {lo[1], 1'b0};
         default: lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   lane_data = {4{d[7:0]}};
         2'b01:   lane_data = {2{d[15:0]}};
         default: lane_data = d;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = lo[0];
         default: is_misaligned = (lo != 2'b00);
      endcase
   endfunction

   assign is_mem     = (reqMemOp == 2'b01) || (reqMemOp == 2'b10);
   assign misaligned = is_misaligned(reqMemSize, reqAddr[1:0]);
   assign accept     = (state == IDLE) && reqValid;

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wd_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if ((state_next == REQ && state != REQ) || (state_next == WAIT && state != WAIT)) begin
         wd_cnt <= '0;
      end else if (state == REQ || state == WAIT) begin
         wd_cnt <= wd_cnt + CNT_W'(1);
      end
   end

   assign expired = (state == REQ || state == WAIT) && (wd_cnt == CNT_LAST);
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (reqValid) state_next = (!is_mem || misaligned) ? RESP : REQ;
         end
         REQ: begin
            if (memGnt) begin
               state_next = we_q ? RESP : WAIT;
            end else if (expired) begin
               state_next = RESP;
               abort      = 1'b1;
            end
         end
         WAIT: begin
            if (memRvalid) begin
               state_next = RESP;
            end else if (expired) begin
               state_next = RESP;
               abort      = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign reqReady   = (state == IDLE);
   assign memReq     = (state == REQ);
   assign memWe      = (state == REQ) && we_q;
   assign respValid  = (state == RESP);
   assign respBusErr = bus_err_q;

   // Memory-side fields are frozen at accept; resp* fields update only when entering RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q         <= 1'b0;
         cap_addr     <= '0;
         cap_op       <= '0;
         cap_size     <= '0;
         memAddr      <= '0;
         memBe        <= '0;
         memWdata     <= '0;
         respRawData  <= '0;
         respAddr     <= '0;
         respMemOp    <= '0;
         respMemSize  <= '0;
         respMisalign <= 1'b0;
         bus_err_q    <= 1'b0;
      end else if (accept) begin
         we_q         <= (reqMemOp == 2'b10);
         cap_addr     <= reqAddr;
         cap_op       <= reqMemOp;
         cap_size     <= reqMemSize;
         memAddr      <= {reqAddr[31:2], 2'b00};
         memBe        <= lane_be(reqMemSize, reqAddr[1:0]);
         memWdata     <= lane_data(reqMemSize, reqWdata);
         respMisalign <= is_mem && misaligned;
         bus_err_q    <= 1'b0;
         if (state_next == RESP) begin
            respAddr    <= reqAddr;
            respMemOp   <= reqMemOp;
            respMemSize <= reqMemSize;
            respRawData <= '0;
         end
      end else if ((state == REQ || state == WAIT) && state_next == RESP) begin
         respAddr    <= cap_addr;
         respMemOp   <= cap_op;
         respMemSize <= cap_size;
         respRawData <= (state == WAIT && !abort) ? memRdata : '0;
         bus_err_q   <= abort;
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed, table-driven bench for dmem_access_unit with a cycle-level memory responder.
module tb_dmem_access_unit;

   logic        clk, rst_n;
   logic        reqValid, reqReady;
   logic [31:0] reqAddr, reqWdata;
   logic [1:0]  reqMemOp, reqMemSize;
   logic        memReq, memWe;
   logic [31:0] memAddr, memWdata;
   logic [3:0]  memBe;
   logic        memGnt, memRvalid;
   logic [31:0] memRdata;
   logic        respValid;
   logic [31:0] respRawData, respAddr;
   logic [1:0]  respMemOp, respMemSize;
   logic        respMisalign, respBusErr;

   int n_chk = 0;
   int n_fail = 0;

   dmem_access_unit #(.MEM_LAT_MAX(4), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqWdata(reqWdata),
      .reqMemOp(reqMemOp), .reqMemSize(reqMemSize),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memBe(memBe), .memWdata(memWdata),
      .memGnt(memGnt), .memRvalid(memRvalid), .memRdata(memRdata),
      .respValid(respValid), .respRawData(respRawData), .respAddr(respAddr),
      .respMemOp(respMemOp), .respMemSize(respMemSize),
      .respMisalign(respMisalign), .respBusErr(respBusErr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          gnt_dly;
      int          rv_dly;
      logic [31:0] rdata;
      bit          spur;
      logic [31:0] exp_maddr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      bit          exp_we;
      int          exp_req;
      int          exp_lat;
      logic [31:0] exp_raw;
      bit          exp_mis;
      bit          exp_bus;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL v%0d %s: got %h, want %h", id, nm, act, exp);
      end
   endtask

   // Entered and left #1 after a rising edge with the DUT idle.
   task automatic run_vec(input int id, input vec_t v);
      int cyc, reqc, waitc;
      bit in_wait, gnt_prev, done, rdy_bad;
      chk(id, "ready_idle", 32'(reqReady), 32'd1);
      reqValid = 1'b1; reqAddr = v.addr; reqWdata = v.wdata;
      reqMemOp = v.op; reqMemSize = v.size;
      memGnt = 1'b0; memRvalid = v.spur; memRdata = v.spur ? v.rdata : 32'h0;
      cyc = 0; reqc = 0; waitc = 0; in_wait = 0; gnt_prev = 0; done = 0; rdy_bad = 0;
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         reqValid = 1'b0;
         if (gnt_prev && v.op == 2'b01) in_wait = 1;
         gnt_prev = 0; memGnt = 1'b0; memRvalid = v.spur;
         if (reqReady) rdy_bad = 1;
         if (memReq) begin
            if (reqc == 0) begin
               chk(id, "memAddr", memAddr, v.exp_maddr);
               chk(id, "memBe", 32'(memBe), 32'(v.exp_be));
               chk(id, "memWdata", memWdata, v.exp_wd);
               chk(id, "memWe", 32'(memWe), 32'(v.exp_we));
            end
            reqc++;
            if (reqc > v.gnt_dly) begin memGnt = 1'b1; gnt_prev = 1; end
         end
         if (respValid) begin
            done = 1;
            chk(id, "latency", 32'(cyc), 32'(v.exp_lat));
            chk(id, "req_cycles", 32'(reqc), 32'(v.exp_req));
            chk(id, "respRawData", respRawData, v.exp_raw);
            chk(id, "respAddr", respAddr, v.addr);
            chk(id, "respMemOp", 32'(respMemOp), 32'(v.op));
            chk(id, "respMemSize", 32'(respMemSize), 32'(v.size));
            chk(id, "respMisalign", 32'(respMisalign), 32'(v.exp_mis));
            chk(id, "respBusErr", 32'(respBusErr), 32'(v.exp_bus));
         end else if (in_wait) begin
            if (waitc >= v.rv_dly) begin memRvalid = 1'b1; memRdata = v.rdata; end
            waitc++;
         end
      end
      if (!done) begin
         n_chk++; n_fail++;
         $display("FAIL v%0d resp_timeout: got no respValid in %0d cycles, want %0d", id, cyc, v.exp_lat);
      end
      chk(id, "ready_low_busy", 32'(rdy_bad), 32'd0);
      memGnt = 1'b0; memRvalid = 1'b0;
      @(posedge clk); #1;
      chk(id, "resp_pulse_end", 32'(respValid), 32'd0);
      chk(id, "resp_addr_hold", respAddr, v.addr);
   endtask

   initial begin
      bit seen;
      //             op     sz     addr          wdata         g  r  rdata         sp maddr         be       wd            we req lat raw         mis bus
      tbl[0]  = '{2'b01, 2'b10, 32'h0000_0100, 32'h1122_3344, 0, 0, 32'hDEAD_BEEF, 0, 32'h0000_0100, 4'b1111, 32'h1122_3344, 0, 1, 3, 32'hDEAD_BEEF, 0, 0};
      tbl[1]  = '{2'b01, 2'b10, 32'h0000_0102, 32'h0,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         0, 0, 1, 32'h0,         1, 0};
      tbl[2]  = '{2'b10, 2'b00, 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'h0,         0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 1, 1, 2, 32'h0,         0, 0};
      tbl[3]  = '{2'b10, 2'b01, 32'h0000_0106, 32'h0000_BEEF, 3, 0, 32'h0,         0, 32'h0000_0104, 4'b1100, 32'hBEEF_BEEF, 1, 4, 5, 32'h0,         0, 0};
      tbl[4]  = '{2'b01, 2'b01, 32'h0000_0005, 32'h0,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         0, 0, 1, 32'h0,         1, 0};
      tbl[5]  = '{2'b01, 2'b00, 32'h0000_0011, 32'hCAFE_F00D, 1, 2, 32'h1234_5678, 0, 32'h0000_0010, 4'b0010, 32'h0D0D_0D0D, 0, 2, 6, 32'h1234_5678, 0, 0};
      tbl[6]  = '{2'b00, 2'b10, 32'h0000_0040, 32'h0,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         0, 0, 1, 32'h0,         0, 0};
      tbl[7]  = '{2'b11, 2'b00, 32'h0000_0043, 32'h0,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         0, 0, 1, 32'h0,         0, 0};
      tbl[8]  = '{2'b10, 2'b11, 32'h0000_0300, 32'h89AB_CDEF, 0, 0, 32'h0,         0, 32'h0000_0300, 4'b1111, 32'h89AB_CDEF, 1, 1, 2, 32'h0,         0, 0};
      tbl[9]  = '{2'b01, 2'b01, 32'h0000_0302, 32'h0000_1234, 0, 0, 32'hA5A5_5A5A, 0, 32'h0000_0300, 4'b1100, 32'h1234_1234, 0, 1, 3, 32'hA5A5_5A5A, 0, 0};
      tbl[10] = '{2'b10, 2'b10, 32'h0000_0001, 32'h0,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         0, 0, 1, 32'h0,         1, 0};
      tbl[11] = '{2'b10, 2'b00, 32'h0000_0000, 32'hFFFF_FF7E, 0, 0, 32'h0,         0, 32'h0000_0000, 4'b0001, 32'h7E7E_7E7E, 1, 1, 2, 32'h0,         0, 0};
      tbl[12] = '{2'b10, 2'b10, 32'h0000_0400, 32'h0BAD_F00D, 1, 0, 32'hFFFF_FFFF, 1, 32'h0000_0400, 4'b1111, 32'h0BAD_F00D, 1, 2, 3, 32'h0,         0, 0};

      rst_n = 1'b0; reqValid = 1'b0; reqAddr = '0; reqWdata = '0; reqMemOp = '0; reqMemSize = '0;
      memGnt = 1'b0; memRvalid = 1'b0; memRdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk(100, "rst_reqReady", 32'(reqReady), 32'd1);
      chk(100, "rst_memReq", 32'(memReq), 32'd0);
      chk(100, "rst_memWe", 32'(memWe), 32'd0);
      chk(100, "rst_memBe", 32'(memBe), 32'd0);
      chk(100, "rst_memAddr", memAddr, 32'd0);
      chk(100, "rst_memWdata", memWdata, 32'd0);
      chk(100, "rst_respValid", 32'(respValid), 32'd0);
      chk(100, "rst_respRawData", respRawData, 32'd0);
      chk(100, "rst_respAddr", respAddr, 32'd0);
      chk(100, "rst_respOpSize", 32'({respMemOp, respMemSize}), 32'd0);
      chk(100, "rst_respFlags", 32'({respMisalign, respBusErr}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);

`ifdef DMEM_TIMEOUT_EN
      // Grant never arrives: eight REQ cycles, then an aborted response.
      run_vec(20, '{2'b01, 2'b10, 32'h0000_0500, 32'h0, 100, 0, 32'h0, 0, 32'h0000_0500, 4'b1111, 32'h0, 0, 8, 9, 32'h0, 0, 1});
      run_vec(21, tbl[0]);
`endif

      // Reset during REQ: memReq must fall before the next clock edge.
      reqValid = 1'b1; reqAddr = 32'h0000_0600; reqWdata = 32'h5555_AAAA; reqMemOp = 2'b10; reqMemSize = 2'b10;
      @(posedge clk); #1;
      reqValid = 1'b0;
      chk(30, "req_before_rst", 32'(memReq), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk(30, "rst_req_memReq", 32'(memReq), 32'd0);
      chk(30, "rst_req_memWe", 32'(memWe), 32'd0);
      chk(30, "rst_req_ready", 32'(reqReady), 32'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset during WAIT, then a late memRvalid must not produce a response.
      reqValid = 1'b1; reqAddr = 32'h0000_0080; reqMemOp = 2'b01; reqMemSize = 2'b10;
      @(posedge clk); #1;
      reqValid = 1'b0;
      chk(31, "wait_req", 32'(memReq), 32'd1);
      memGnt = 1'b1;
      @(posedge clk); #1;
      memGnt = 1'b0;
      chk(31, "wait_no_req", 32'(memReq), 32'd0);
      chk(31, "wait_ready", 32'(reqReady), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk(31, "rst_wait_ready", 32'(reqReady), 32'd1);
      chk(31, "rst_wait_respValid", 32'(respValid), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      memRvalid = 1'b1; memRdata = 32'hBAAD_CAFE;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (respValid) seen = 1;
      end
      memRvalid = 1'b0;
      chk(31, "spurious_rvalid_resp", 32'(seen), 32'd0);
      chk(31, "spurious_rvalid_raw", respRawData, 32'd0);

      run_vec(32, tbl[5]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
